// File: rtl/jpeg_output_blk_fifo_if.sv
// jpeg_output_blk_fifo_if: write, read and status signals of the block-committed output FIFO
interface jpeg_output_blk_fifo_if #(
    parameter int WIDTH  = 32,
    parameter int IDX_W  = 6,
    parameter int BLOCKS = 8
);
    logic                       flush_i;
    logic [IDX_W-1:0]           wr_idx_i;
    logic [WIDTH-1:0]           data_in_i;
    logic                       push_i;
    logic                       last_i;
    logic                       accept_o;
    logic                       pop_i;
    logic [WIDTH-1:0]           data_out_o;
    logic                       valid_o;
    logic [31:0]                level_o;
    logic [$clog2(BLOCKS):0]    blocks_o;
    logic                       overflow_o;

    modport master (
        output flush_i, wr_idx_i, data_in_i, push_i, last_i, pop_i,
        input  accept_o, data_out_o, valid_o, level_o, blocks_o, overflow_o
    );

    modport slave (
        input  flush_i, wr_idx_i, data_in_i, push_i, last_i, pop_i,
        output accept_o, data_out_o, valid_o, level_o, blocks_o, overflow_o
    );
endinterface

// File: rtl/jpeg_output_blk_fifo.sv
// jpeg_output_blk_fifo: blocks are written in any word order, committed whole, and streamed out in address order
module jpeg_output_blk_fifo #(
    parameter int WIDTH  = 32,
    parameter int IDX_W  = 6,
    parameter int BLOCKS = 8
) (
    input logic clk_i,
    input logic rst_i,
    jpeg_output_blk_fifo_if.slave bus
);
    localparam int B  = 2 ** IDX_W;
    localparam int SW = $clog2(BLOCKS);
    localparam int PW = SW + 1;

    logic [WIDTH-1:0] mem [BLOCKS*B];
    logic [WIDTH-1:0] dout_q;
    logic [PW-1:0]    wr_blk, rd_blk, fe_blk, used;
    logic [IDX_W-1:0] fe_word;
    logic [31:0]      level_q;
    logic             valid_q, last_q, ovf_q, accept, wr_en, commit, take, fetch;

    // fe_* runs one word ahead of the consumer; rd_blk frees a slot only once its last word is popped
    always_comb begin
        used   = wr_blk - rd_blk;
        accept = used != PW'(BLOCKS);
        wr_en  = bus.push_i & accept & !bus.flush_i;
        commit = wr_en & bus.last_i;
        take   = valid_q & bus.pop_i;
        fetch  = (fe_blk != wr_blk) & (!valid_q | take);
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[{wr_blk[SW-1:0], bus.wr_idx_i}] <= bus.data_in_i;
        if (fetch) dout_q <= mem[{fe_blk[SW-1:0], fe_word}];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_blk  <= '0;
            rd_blk  <= '0;
            fe_blk  <= '0;
            fe_word <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (bus.flush_i) begin
            wr_blk  <= '0;
            rd_blk  <= '0;
            fe_blk  <= '0;
            fe_word <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (commit) wr_blk <= wr_blk + PW'(1);
            if (bus.push_i && !accept) ovf_q <= 1'b1;
            level_q <= level_q + (commit ? 32'(B) : 32'd0) - (take ? 32'd1 : 32'd0);
            if (fetch) begin
                fe_word <= fe_word + IDX_W'(1);
                fe_blk  <= fe_blk + PW'(&fe_word);
                last_q  <= &fe_word;
            end
            valid_q <= fetch | (valid_q & !take);
            if (take && last_q) rd_blk <= rd_blk + PW'(1);
        end
    end

    assign bus.accept_o   = accept;
    assign bus.data_out_o = dout_q;
    assign bus.valid_o    = valid_q;
    assign bus.level_o    = level_q;
    assign bus.blocks_o   = used;
    assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_jpeg_output_blk_fifo.sv
// tb_jpeg_output_blk_fifo: vector table plus scoreboarded block sequences for jpeg_output_blk_fifo
module tb_jpeg_output_blk_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_got = 0;
    bit   sb_en = 1'b0;
    bit   prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    jpeg_output_blk_fifo_if #(.WIDTH(32), .IDX_W(6), .BLOCKS(8)) bus ();
    jpeg_output_blk_fifo #(.WIDTH(32), .IDX_W(6), .BLOCKS(8)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    typedef struct {
        logic        flush, push, last, pop;
        logic [5:0]  idx;
        logic [31:0] din;
        logic        ev;
        logic [31:0] elev;
        logic [3:0]  eblk;
        logic        ea, eo, dc;
        logic [31:0] edat;
    } vec_t;
    vec_t tbl[10];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // scoreboard: a word leaves on the edge after a negedge that sees valid & pop
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.valid_o), 32'd1);
                chk("hold_data", bus.data_out_o, prev_data);
            end
            if (bus.valid_o && bus.pop_i) begin
                if (q.size() == 0) chk("unexpected_word", bus.data_out_o, 32'hxxxx_xxxx);
                else chk("sb_data", bus.data_out_o, q.pop_front());
                n_got++;
            end
            prev_hold = bus.valid_o && !bus.pop_i;
            prev_data = bus.data_out_o;
        end else prev_hold = 1'b0;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush_i = 0; bus.push_i = 0; bus.last_i = 0; bus.pop_i = 0;
        bus.wr_idx_i = '0; bus.data_in_i = '0;
    endtask

    task automatic do_reset();
        sb_en = 0;
        idle();
        rst = 1;
        repeat (2) tick();
        rst = 0;
        q.delete();
        tick();
        sb_en = 1;
    endtask

    task automatic do_flush();
        sb_en = 0;
        bus.flush_i = 1;
        tick();
        bus.flush_i = 0;
        q.delete();
        tick();
        sb_en = 1;
    endtask

    task automatic check_state(string nm, logic v, logic [31:0] lev, logic [3:0] blk, logic a, logic o);
        chk({nm, "_valid"}, 32'(bus.valid_o), 32'(v));
        chk({nm, "_level"}, bus.level_o, lev);
        chk({nm, "_blocks"}, 32'(bus.blocks_o), 32'(blk));
        chk({nm, "_accept"}, 32'(bus.accept_o), 32'(a));
        chk({nm, "_overflow"}, 32'(bus.overflow_o), 32'(o));
    endtask

    // mode 0 ascending, 1 descending, 2 shuffled; expected words queued in address order at commit
    task automatic write_block(input int mode, input bit pop_on_last);
        logic [31:0] d[64];
        int ord[64];
        int c;
        for (int i = 0; i < 64; i++) begin
            d[i] = $urandom;
            ord[i] = (mode == 1) ? 63 - i : i;
        end
        if (mode == 2) begin
            for (int i = 63; i > 0; i--) begin
                int j;
                int t;
                j = $urandom_range(0, i);
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
        end
        for (c = 0; c < 5000 && !bus.accept_o; c++) tick();
        if (!bus.accept_o) chk("accept_wait", 32'(bus.accept_o), 32'd1);
        for (int k = 0; k < 64; k++) begin
            bus.push_i = 1;
            bus.wr_idx_i = 6'(ord[k]);
            bus.data_in_i = d[ord[k]];
            bus.last_i = (k == 63);
            if (k == 63) begin
                for (int i = 0; i < 64; i++) q.push_back(d[i]);
                if (pop_on_last) bus.pop_i = 1;
            end
            tick();
        end
        bus.push_i = 0;
        bus.last_i = 0;
        if (pop_on_last) bus.pop_i = 0;
    endtask

    task automatic drain();
        bus.pop_i = 1;
        for (int c = 0; c < 3000; c++) begin
            if (q.size() == 0 && !bus.valid_o) break;
            tick();
        end
        bus.pop_i = 0;
        chk("drain_left", q.size(), 0);
        chk("drain_level", bus.level_o, 0);
        chk("drain_valid", 32'(bus.valid_o), 0);
    endtask

    initial begin
        int base;
        int target;
        idle();
        tbl[0] = '{0,0,0,0,6'd0, 32'd0,        0,32'd0, 4'd0,1,0,0,32'd0};
        tbl[1] = '{0,1,0,0,6'd3, 32'hA5A50003, 0,32'd0, 4'd0,1,0,0,32'd0};
        tbl[2] = '{0,1,1,0,6'd0, 32'h5A5A0000, 0,32'd64,4'd1,1,0,0,32'd0};
        tbl[3] = '{0,0,0,0,6'd0, 32'd0,        1,32'd64,4'd1,1,0,1,32'h5A5A0000};
        tbl[4] = '{0,0,0,1,6'd0, 32'd0,        1,32'd63,4'd1,1,0,0,32'd0};
        tbl[5] = '{0,0,0,1,6'd0, 32'd0,        1,32'd62,4'd1,1,0,0,32'd0};
        tbl[6] = '{0,0,0,1,6'd0, 32'd0,        1,32'd61,4'd1,1,0,1,32'hA5A50003};
        tbl[7] = '{1,1,1,1,6'd0, 32'hC0DE0000, 0,32'd0, 4'd0,1,0,0,32'd0};
        tbl[8] = '{0,0,0,0,6'd0, 32'd0,        0,32'd0, 4'd0,1,0,0,32'd0};
        tbl[9] = '{0,0,0,1,6'd0, 32'd0,        0,32'd0, 4'd0,1,0,0,32'd0};

        repeat (2) tick();
        check_state("in_reset", 0, 0, 0, 1, 0);
        rst = 0;

        // partial block, undefined words still emitted, flush beats push/last/pop
        for (int r = 0; r < 10; r++) begin
            bus.flush_i = tbl[r].flush; bus.push_i = tbl[r].push; bus.last_i = tbl[r].last;
            bus.pop_i = tbl[r].pop; bus.wr_idx_i = tbl[r].idx; bus.data_in_i = tbl[r].din;
            tick();
            check_state($sformatf("row%0d", r), tbl[r].ev, tbl[r].elev, tbl[r].eblk, tbl[r].ea, tbl[r].eo);
            if (tbl[r].dc) chk($sformatf("row%0d_data", r), bus.data_out_o, tbl[r].edat);
        end
        idle();

        // descending writes, valid one cycle after commit, 64 words back-to-back
        do_reset();
        write_block(1, 0);
        check_state("commit", 0, 64, 1, 1, 0);
        tick();
        chk("valid_after_commit", 32'(bus.valid_o), 1);
        base = n_got;
        bus.pop_i = 1;
        repeat (64) tick();
        bus.pop_i = 0;
        chk("burst_words", n_got - base, 64);
        check_state("burst_end", 0, 0, 0, 1, 0);

        // fill all slots, dropped push, slot release on the last popped word
        do_flush();
        for (int b = 0; b < 8; b++) write_block(0, 0);
        check_state("full", 1, 512, 8, 0, 0);
        bus.push_i = 1; bus.last_i = 1; bus.data_in_i = 32'hDEAD0000;
        tick();
        idle();
        check_state("dropped", 1, 512, 8, 0, 1);
        bus.pop_i = 1;
        repeat (63) tick();
        chk("accept_before_free", 32'(bus.accept_o), 0);
        tick();
        bus.pop_i = 0;
        check_state("freed", 1, 448, 7, 1, 1);
        drain();
        chk("overflow_sticky", 32'(bus.overflow_o), 1);

        // simultaneous commit and pop at level 10, pointers past the slot wrap
        write_block(0, 0);
        tick();
        bus.pop_i = 1;
        repeat (54) tick();
        bus.pop_i = 0;
        chk("level_10", bus.level_o, 10);
        write_block(0, 1);
        chk("commit_pop_level", bus.level_o, 73);
        chk("commit_pop_blocks", 32'(bus.blocks_o), 2);
        drain();
        do_flush();
        check_state("flushed", 0, 0, 0, 1, 0);

        // random backpressure over 20 blocks
        target = n_got + 20 * 64;
        fork
            begin
                for (int b = 0; b < 20; b++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    write_block(2, 0);
                end
            end
            begin
                for (int c = 0; c < 20000 && n_got < target; c++) begin
                    bus.pop_i = $urandom_range(0, 1) != 0;
                    tick();
                end
                bus.pop_i = 0;
            end
        join
        chk("rand_words", n_got, target);
        chk("rand_left", q.size(), 0);
        tick();
        chk("rand_valid", 32'(bus.valid_o), 0);

        // asynchronous reset in the middle of a block
        write_block(2, 0);
        tick();
        for (int k = 0; k < 20; k++) begin
            bus.push_i = 1; bus.wr_idx_i = 6'(k); bus.data_in_i = $urandom;
            tick();
        end
        #2;
        sb_en = 0;
        rst = 1;
        bus.push_i = 0;
        #1;
        check_state("async_rst", 0, 0, 0, 1, 0);
        q.delete();
        repeat (2) tick();
        rst = 0;
        tick();
        sb_en = 1;
        write_block(1, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/jpeg_output_blk_fifo.md
JPEG_OUTPUT_BLK_FIFO -- requirements
Module: jpeg_output_blk_fifo

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits.
REQ-002 Parameter IDX_W, default 6: block index width; block size B = 2^IDX_W words.
REQ-003 Parameter BLOCKS, default 8, power of two >= 2: number of block slots; RAM depth = BLOCKS*B.
REQ-004 clk_i  input  1: single clock, all logic on the rising edge.
REQ-005 rst_i  input  1: reset, asynchronous and active-high.
REQ-006 flush_i  input  1: synchronous clear of all pointers, counters and flags.
REQ-007 wr_idx_i  input  IDX_W: word index within the current write block (out-of-order writes permitted).
REQ-008 data_in_i  input  WIDTH: write data.
REQ-009 push_i  input  1: write data_in_i at {wr_blk, wr_idx_i}.
REQ-010 last_i  input  1: qualifies push_i; this write completes and commits the current block.
REQ-011 accept_o  output  1: a free block slot exists; writes are accepted.
REQ-012 pop_i  input  1: consumer takes data_out_o this cycle when valid_o is high.
REQ-013 data_out_o  output  WIDTH: head word, in ascending address order within each block.
REQ-014 valid_o  output  1: data_out_o holds a committed word.
REQ-015 level_o  output  32: committed words not yet popped.
REQ-016 blocks_o  output  $clog2(BLOCKS)+1: committed blocks not fully popped.
REQ-017 overflow_o  output  1: sticky flag, a push was dropped.

Function
REQ-018 Write block pointer wr_blk and read block pointer rd_blk each carry $clog2(BLOCKS)+1 bits; the low bits address a slot, the MSB distinguishes full from empty, and wrap is modulo 2*BLOCKS.
REQ-019 accept_o = 1 unless every slot is committed or still being read (wr_blk - rd_blk == BLOCKS).
REQ-020 push_i with accept_o = 1 writes RAM on the same edge; push_i with accept_o = 0 writes nothing and sets overflow_o.
REQ-021 push_i & last_i & accept_o advances wr_blk by 1 and adds B to level_o on that edge; no other write moves wr_blk.
REQ-022 Unwritten words of a committed block read back undefined data but are still emitted, so exactly B words leave per block.
REQ-023 The read side emits only committed words, word address rd_blk*B + rd_word, with rd_word incrementing 0..B-1; after word B-1 it advances rd_blk.
REQ-024 RAM read latency is 1 cycle. A commit at edge N into an empty FIFO drives valid_o high from edge N+1.
REQ-025 With pop_i held high and data available, one word is delivered per cycle with no bubbles, including across block boundaries.
REQ-026 valid_o & !pop_i holds data_out_o and valid_o stable until popped; no word is lost or duplicated.
REQ-027 pop_i while valid_o = 0 is ignored; level_o is unchanged.
REQ-028 level_o next = level_o + (commit ? B : 0) - (valid_o & pop_i ? 1 : 0); simultaneous commit and pop apply both.
REQ-029 A slot is freed (accept_o may rise) on the edge its final word is popped; a commit and a free in the same cycle leave blocks_o unchanged.
REQ-030 Writes to the current open block never disturb words of committed blocks being read.
REQ-031 flush_i takes priority over push_i and pop_i in the same cycle; it clears all state and drops the partially written block.

Reset
REQ-032 While rst_i is high, and on the flush_i edge: valid_o = 0, level_o = 0, blocks_o = 0, overflow_o = 0, accept_o = 1, and all pointers = 0.
REQ-033 RAM contents are not reset.
REQ-034 Reset asserted mid-transfer discards all in-flight data; after release the FIFO behaves as empty.

Verification
REQ-035 Reset, then write idx 63..0 descending with last_i on the final write (WIDTH 32, IDX_W 6) -> valid_o rises 1 cycle after commit; with pop_i = 1 the 64 words emerge in idx order 0..63 on consecutive cycles; level_o goes 64 -> 0.
REQ-036 Commit 8 blocks with no pops -> accept_o = 0 and blocks_o = 8; a 9th push is dropped and overflow_o = 1; popping 64 words -> accept_o = 1 on the edge the last word is popped; overflow_o stays 1 until flush.
REQ-037 Random pop_i backpressure over 20 blocks -> output sequence matches the model exactly; data_out_o is stable whenever valid_o & !pop_i.
REQ-038 Commit and pop in the same cycle with level_o = 10 -> level_o = 73 next cycle; pointers wrap past slot 7 to 0 correctly.
REQ-039 flush_i asserted together with push_i & last_i and with pop_i -> all outputs take their reset values next cycle and no commit occurs.
REQ-040 Assert rst_i asynchronously mid-block -> outputs clear immediately without waiting for a clock edge; new data written after release reads back correctly.
